// File: rtl/hop_chain_tester.sv
// Launch/capture end for hop-chain latency benchmarks.
// Fires a start pulse into the chain, counts cycles until chain_out rises,
// compares against EXP_LAT, and reports pass/fail after NUM_TRIALS trials.
module hop_chain_tester #(
    parameter int unsigned EXP_LAT    = 9,
    parameter int unsigned TIMEOUT    = 31,
    parameter int unsigned CNT_W      = 5,
    parameter int unsigned NUM_TRIALS = 4,
    parameter int unsigned GAP_CYC    = 2
) (
    input  logic             clock0,
    input  logic             rst1_n,
    input  logic             go,
    input  logic             chain_out,
    output logic             start,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_mismatch,
    output logic             err_timeout,
    output logic             err_spurious,
    output logic [CNT_W-1:0] lat_meas,
    output logic [3:0]       trial_idx
);

    localparam int unsigned GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [GAP_W-1:0] gcnt;
    logic [GAP_W-1:0] gcnt_nxt;
    logic [GAP_W-1:0] gcnt_inc;
    logic [CNT_W-1:0] lat_nxt;
    logic [3:0]       trial_nxt;
    logic             em_nxt;
    logic             et_nxt;
    logic             es_nxt;
    logic             start_nxt;
    logic             en_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             pass_nxt;

    assign gcnt_inc = gcnt + GAP_W'(1);

    // State and registered-output flops; reset aborts any run immediately.
    always_ff @(posedge clock0 or negedge rst1_n) begin
        if (!rst1_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            gcnt         <= '0;
            lat_meas     <= '0;
            trial_idx    <= '0;
            err_mismatch <= 1'b0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
            start        <= 1'b0;
            en           <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            gcnt         <= gcnt_nxt;
            lat_meas     <= lat_nxt;
            trial_idx    <= trial_nxt;
            err_mismatch <= em_nxt;
            err_timeout  <= et_nxt;
            err_spurious <= es_nxt;
            start        <= start_nxt;
            en           <= en_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            pass         <= pass_nxt;
        end
    end

    // Next-state: arrival wins over timeout when both land in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (go) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_nxt = chain_out ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (chain_out)                       state_nxt = S_GAP;
                else if (cnt == CNT_W'(TIMEOUT))     state_nxt = S_DONE;
            end
            S_GAP: begin
                if (!chain_out && (gcnt_inc == GAP_W'(GAP_CYC)))
                    state_nxt = (trial_idx < 4'(NUM_TRIALS)) ? S_LAUNCH : S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next-values, registered alongside the state.
    always_comb begin
        cnt_nxt   = cnt;
        gcnt_nxt  = gcnt;
        lat_nxt   = lat_meas;
        trial_nxt = trial_idx;
        em_nxt    = err_mismatch;
        et_nxt    = err_timeout;
        es_nxt    = err_spurious;
        case (state)
            S_IDLE, S_DONE: begin
                if (go) begin
                    lat_nxt   = '0;
                    trial_nxt = '0;
                    em_nxt    = 1'b0;
                    et_nxt    = 1'b0;
                    es_nxt    = 1'b0;
                end
            end
            S_LAUNCH: begin
                if (chain_out) es_nxt = 1'b1;
            end
            S_WAIT: begin
                if (chain_out) begin
                    lat_nxt   = cnt;
                    trial_nxt = trial_idx + 4'd1;
                    gcnt_nxt  = '0;
                    if (cnt != CNT_W'(EXP_LAT)) em_nxt = 1'b1;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    lat_nxt   = CNT_W'(TIMEOUT);
                    trial_nxt = trial_idx + 4'd1;
                    et_nxt    = 1'b1;
                end
            end
            S_GAP: begin
                gcnt_nxt = chain_out ? '0 : gcnt_inc;
            end
            default: ;
        endcase

        // Latency counter: zero in the launch cycle, saturating at TIMEOUT.
        if (state_nxt == S_LAUNCH)
            cnt_nxt = '0;
        else if (((state == S_LAUNCH) || (state == S_WAIT)) && (cnt != CNT_W'(TIMEOUT)))
            cnt_nxt = cnt + CNT_W'(1);

        start_nxt = (state_nxt == S_LAUNCH);
        busy_nxt  = (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT) || (state_nxt == S_GAP);
        en_nxt    = busy_nxt;
        done_nxt  = (state_nxt == S_DONE);
        pass_nxt  = done_nxt && !(em_nxt || et_nxt || es_nxt);
    end

endmodule

// File: tb/tb_hop_chain_tester.sv
// Bench for hop_chain_tester: a configurable flop chain closes the loop and
// expected timing/results come from the chain's delay and pulse width.
module tb_hop_chain_tester;

    localparam int unsigned EXP_LAT    = 9;
    localparam int unsigned TIMEOUT    = 31;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned NUM_TRIALS = 4;
    localparam int unsigned GAP_CYC    = 2;

    logic             clock0 = 1'b0;
    logic             rst1_n = 1'b0;
    logic             go = 1'b0;
    logic             chain_out;
    logic             start, en, busy, done, pass;
    logic             err_mismatch, err_timeout, err_spurious;
    logic [CNT_W-1:0] lat_meas;
    logic [3:0]       trial_idx;

    int checks = 0;
    int errors = 0;

    // Chain model: delay chain_d flops, arrival stretched to chain_s cycles; tie 1=low, 2=high.
    int          chain_d = 9;
    int          chain_s = 1;
    int          tie_mode = 0;
    logic [31:0] sr = '0;

    always #5 clock0 = ~clock0;

    always @(posedge clock0) sr <= {sr[30:0], start};

    always_comb begin
        chain_out = 1'b0;
        if (tie_mode == 2) chain_out = 1'b1;
        else if (tie_mode == 0)
            for (int i = 0; i < chain_s; i++) chain_out = chain_out | sr[chain_d - 1 + i];
    end

    hop_chain_tester #(
        .EXP_LAT(EXP_LAT), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W),
        .NUM_TRIALS(NUM_TRIALS), .GAP_CYC(GAP_CYC)
    ) dut (
        .clock0(clock0), .rst1_n(rst1_n), .go(go), .chain_out(chain_out),
        .start(start), .en(en), .busy(busy), .done(done), .pass(pass),
        .err_mismatch(err_mismatch), .err_timeout(err_timeout),
        .err_spurious(err_spurious), .lat_meas(lat_meas), .trial_idx(trial_idx)
    );

    // Observations gathered during one run.
    int               start_q[$];
    logic [CNT_W-1:0] lat_q[$];
    int               done_cyc;
    int               bad_en;

    function automatic logic [7:0] flags();
        return {start, en, busy, done, pass, err_mismatch, err_timeout, err_spurious};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clock0);
    endtask

    // Pulse go and record start pulses, per-trial latencies and completion cycle.
    task automatic do_run(input bit poke_go);
        logic [3:0] prev;
        start_q.delete();
        lat_q.delete();
        done_cyc = -1;
        bad_en   = 0;
        @(negedge clock0) go = 1'b1;
        @(negedge clock0) go = 1'b0;
        prev = 4'd0;
        for (int c = 0; c < 300; c++) begin
            if (c > 0) @(negedge clock0);
            if (start === 1'b1) start_q.push_back(c);
            if (trial_idx !== prev) begin
                lat_q.push_back(lat_meas);
                prev = trial_idx;
            end
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (busy !== 1'b1 || en !== 1'b1) bad_en++;
            go = poke_go ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        go = 1'b0;
        if (done_cyc < 0) begin
            checks++; errors++;
            $display("FAIL run_budget: done never seen within 300 cycles");
        end
    endtask

    task automatic test_reset();
        rst1_n = 1'b0;
        idle(3);
        checks++;
        if ({flags(), lat_meas, trial_idx} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %h expected 0", {flags(), lat_meas, trial_idx}); end
        @(negedge clock0) rst1_n = 1'b1;
        idle(5);
        checks++;
        if ({flags(), lat_meas, trial_idx} !== '0)
            begin errors++; $display("FAIL post_release_outputs: got %h expected 0", {flags(), lat_meas, trial_idx}); end
    endtask

    // Full run through a well-behaved chain of delay d and pulse width s.
    task automatic test_chain(input int d, input int s, input bit poke_go, input string nm);
        int period;
        logic [7:0] exp_f;
        chain_d = d; chain_s = s; tie_mode = 0;
        idle(20);
        do_run(poke_go);
        period = d + (s - 1) + int'(GAP_CYC) + 1;
        checks++;
        if (start_q.size() != int'(NUM_TRIALS))
            begin errors++; $display("FAIL %s start_count: got %0d expected %0d", nm, start_q.size(), NUM_TRIALS); end
        for (int i = 1; i < start_q.size(); i++) begin
            checks++;
            if (start_q[i] - start_q[i-1] != period)
                begin errors++; $display("FAIL %s start_period[%0d]: got %0d expected %0d", nm, i, start_q[i] - start_q[i-1], period); end
        end
        checks++;
        if (lat_q.size() != int'(NUM_TRIALS))
            begin errors++; $display("FAIL %s trial_count: got %0d expected %0d", nm, lat_q.size(), NUM_TRIALS); end
        foreach (lat_q[i]) begin
            checks++;
            if (lat_q[i] !== CNT_W'(d))
                begin errors++; $display("FAIL %s lat_meas[%0d]: got %0d expected %0d", nm, i, lat_q[i], d); end
        end
        checks++;
        if (done_cyc != int'(NUM_TRIALS) * period)
            begin errors++; $display("FAIL %s done_cycle: got %0d expected %0d", nm, done_cyc, int'(NUM_TRIALS) * period); end
        exp_f = {1'b0, 1'b0, 1'b0, 1'b1, 1'(d == int'(EXP_LAT)), 1'(d != int'(EXP_LAT)), 1'b0, 1'b0};
        checks++;
        if (flags() !== exp_f)
            begin errors++; $display("FAIL %s final_flags: got %b expected %b", nm, flags(), exp_f); end
        checks++;
        if (trial_idx !== 4'(NUM_TRIALS) || lat_meas !== CNT_W'(d))
            begin errors++; $display("FAIL %s final_idx_lat: got %0d/%0d expected %0d/%0d", nm, trial_idx, lat_meas, NUM_TRIALS, d); end
        checks++;
        if (bad_en != 0)
            begin errors++; $display("FAIL %s en_busy_during_run: got %0d low cycles expected 0", nm, bad_en); end
    endtask

    task automatic test_ideal();   test_chain(9, 1, 1'b0, "ideal");   endtask
    task automatic test_long();    test_chain(10, 1, 1'b0, "long");   endtask
    task automatic test_stretch(); test_chain(9, 3, 1'b0, "stretch"); endtask

    task automatic test_timeout();
        tie_mode = 1;
        idle(20);
        do_run(1'b0);
        checks++;
        if (start_q.size() != 1)
            begin errors++; $display("FAIL timeout start_count: got %0d expected 1", start_q.size()); end
        checks++;
        if (done_cyc != int'(TIMEOUT) + 1)
            begin errors++; $display("FAIL timeout done_cycle: got %0d expected %0d", done_cyc, TIMEOUT + 1); end
        checks++;
        if (lat_meas !== CNT_W'(TIMEOUT) || trial_idx !== 4'd1)
            begin errors++; $display("FAIL timeout lat_idx: got %0d/%0d expected %0d/1", lat_meas, trial_idx, TIMEOUT); end
        checks++;
        if (flags() !== 8'b0001_0010)
            begin errors++; $display("FAIL timeout flags: got %b expected 00010010", flags()); end
    endtask

    task automatic test_spurious();
        tie_mode = 2;
        idle(20);
        do_run(1'b0);
        checks++;
        if (done_cyc != 1 || start_q.size() != 1)
            begin errors++; $display("FAIL spurious timing: got done@%0d starts=%0d expected done@1 starts=1", done_cyc, start_q.size()); end
        checks++;
        if (flags() !== 8'b0001_0001)
            begin errors++; $display("FAIL spurious flags: got %b expected 00010001", flags()); end
        checks++;
        if (trial_idx !== 4'd0 || lat_meas !== '0)
            begin errors++; $display("FAIL spurious idx_lat: got %0d/%0d expected 0/0", trial_idx, lat_meas); end
        tie_mode = 0;
    endtask

    task automatic test_reset_mid();
        int nstart;
        bit hit;
        chain_d = 9; chain_s = 1; tie_mode = 0;
        idle(20);
        @(negedge clock0) go = 1'b1;
        @(negedge clock0) go = 1'b0;
        nstart = 0;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) @(negedge clock0);
            if (start === 1'b1) nstart++;
            if (nstart == 2) begin
                hit = 1'b1;
                break;
            end
        end
        idle(3);
        checks++;
        if (!hit || trial_idx !== 4'd1 || busy !== 1'b1)
            begin errors++; $display("FAIL midrun_precondition: got idx=%0d busy=%b expected 1/1", trial_idx, busy); end
        rst1_n = 1'b0;
        #1;
        checks++;
        if ({flags(), lat_meas, trial_idx} !== '0)
            begin errors++; $display("FAIL midrun_reset_outputs: got %h expected 0", {flags(), lat_meas, trial_idx}); end
        @(negedge clock0) rst1_n = 1'b1;
        idle(4);
        checks++;
        if ({flags(), trial_idx} !== '0)
            begin errors++; $display("FAIL midrun_release_outputs: got %h expected 0", {flags(), trial_idx}); end
        test_chain(9, 1, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int d;
            int s;
            d = int'($urandom_range(7, 12));
            s = int'($urandom_range(1, 3));
            idle(int'($urandom_range(0, 6)));
            test_chain(d, s, 1'b1, $sformatf("random%0d_d%0d_s%0d", r, d, s));
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_long();
        test_timeout();
        test_spurious();
        test_stretch();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule

// File: doc/hop_chain_tester.md
Name: hop_chain_tester

Overview:
- Launch/capture end for the hop-chain latency benchmarks.
- Drives `start` and `en` into a flop chain under test and receives the chain's terminal output (ff9 of an 8-hop chain).
- For each trial it measures the cycle latency from launch to arrival and checks it against an expected value.
- After a programmable number of trials it reports pass/fail with error flags.

Parameters:
- EXP_LAT, 9, expected cycles from the `start`-high cycle to the `chain_out`-high cycle.
- TIMEOUT, 31, maximum latency count before a trial is declared lost; must be less than 2^CNT_W.
- CNT_W, 5, width of the latency counter and of `lat_meas`.
- NUM_TRIALS, 4, trials per run; range 1..15.
- GAP_CYC, 2, consecutive low `chain_out` cycles required between trials.

Ports:
- clock0  in  1  single rising-edge clock.
- rst1_n  in  1  reset, asynchronous, active-low.
- go  in  1  run request, sampled in IDLE/DONE.
- chain_out  in  1  terminal flop of the chain under test.
- start  out  1  one-cycle launch pulse into the chain head, registered.
- en  out  1  chain enable, registered; high for the whole run.
- busy  out  1  high in LAUNCH/WAIT/GAP.
- done  out  1  level; high in DONE until next go.
- pass  out  1  done & no error flag set.
- err_mismatch  out  1  sticky: some trial's latency ≠ EXP_LAT.
- err_timeout  out  1  sticky: arrival not seen by TIMEOUT.
- err_spurious  out  1  sticky: chain_out high during LAUNCH.
- lat_meas  out  CNT_W  latency of the most recent trial.
- trial_idx  out  4  trials completed this run.

Behaviour:
- Reset (rst1_n low, asynchronous): state=IDLE; all outputs 0, including `lat_meas` and `trial_idx`.
  - Reset mid-run aborts immediately.
  - No output glitches high on release.
- All outputs are registered. `chain_out` is used directly; the chain shares clock0, so no synchronizer is needed.
- States: IDLE, LAUNCH, WAIT, GAP, DONE.
- IDLE/DONE, go=1:
  - Clear error flags, `trial_idx` and `lat_meas`.
  - Set en=1 and go to LAUNCH.
  - go=0 holds the state.
  - go while busy is ignored.
- LAUNCH (exactly 1 cycle), cycle T:
  - start=1, cnt=0.
  - If chain_out=1 here: set err_spurious, go to DONE.
  - Otherwise go to WAIT.
- WAIT: cnt increments every cycle, so cnt=k in cycle T+k.
  - chain_out=1: lat_meas<=cnt; set err_mismatch if cnt≠EXP_LAT; trial_idx++; go to GAP.
  - chain_out=0 and cnt==TIMEOUT: lat_meas<=TIMEOUT; set err_timeout; trial_idx++; go to DONE (run aborted).
  - Arrival in the same cycle as cnt==TIMEOUT counts as arrival, not timeout.
- GAP: gcnt counts consecutive chain_out=0 cycles.
  - Any chain_out=1 resets gcnt to 0. This is not an error; it drains multi-cycle pulses.
  - At gcnt==GAP_CYC: go to LAUNCH if trial_idx<NUM_TRIALS, else DONE.
  - For a 1-cycle arrival at T+EXP_LAT, the next LAUNCH is at T+EXP_LAT+GAP_CYC+1.
- DONE:
  - done=1, en=0, start=0.
  - pass = no error flag set.
  - lat_meas and trial_idx hold.
- en: set on the IDLE/DONE→LAUNCH transition, cleared on entry to DONE, IDLE or reset.
- Widths:
  - cnt saturates at TIMEOUT; it never wraps.
  - trial_idx is 4-bit; NUM_TRIALS ≤ 15 is guaranteed by the parameter range.

Test Plan:
1. Ideal 9-flop chain model (1-cycle delay per flop, start→ff1…ff9), defaults, go pulse → start pulses 12 cycles apart. Each trial lat_meas=9. After 4 trials: done=1, pass=1, trial_idx=4, all err flags 0, en=0.
2. 10-flop chain model → lat_meas=10 every trial; err_mismatch=1, pass=0, done after trial_idx=4; start period 13 cycles.
3. chain_out tied 0 → single start pulse; at cnt=31: err_timeout=1, lat_meas=31, trial_idx=1, done=1, pass=0.
4. chain_out tied 1 → go → err_spurious=1 in the LAUNCH cycle, next cycle done=1, trial_idx=0, pass=0.
5. Chain model stretching arrival to 3 cycles → lat_meas=9, GAP drains until 2 low cycles, next start 14 cycles after previous; pass=1.
6. Assert rst1_n low in WAIT of trial 2 → same cycle: start=0, en=0, busy=0, trial_idx=0. Release, then go → fresh run completes with pass=1; go while busy has no effect.
